// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 debug-UART receiver feeding an A5-framed command parser (channel + signed value).
// Optional feature macro UART_CMD_CHECKSUM_EN adds a fifth XOR checksum byte to every packet.
module uart_cmd_rx #(
  parameter int DIV          = 12,
  parameter int W            = 16,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_i,
  output logic [7:0]   byte_o,
  output logic         byte_valid_o,
  output logic         frame_err_o,
  output logic         cmd_valid_o,
  output logic [1:0]   cmd_ch_o,
  output logic [W-1:0] cmd_value_o,
  output logic         cksum_err_o
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF_LD  = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LD  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam int TO_CYC = TIMEOUT_BITS * DIV;
  localparam int GW     = $clog2(TO_CYC + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(TO_CYC);
  localparam logic [GW-1:0] GAP_ONE = GW'(1);
  localparam logic [7:0] SYNC_BYTE  = 8'hA5;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {P_SYNC, P_CH, P_HI, P_LO, P_CK} p_state_t;

`ifdef UART_CMD_CHECKSUM_EN
  function automatic logic [7:0] cksum_f(input logic [1:0] ch, input logic [7:0] hi, input logic [7:0] lo);
    cksum_f = {6'd0, ch} ^ hi ^ lo;
  endfunction
`endif

  logic            sync1_r, sync2_r, rxs_prev_r;
  logic            rxs_s, fall_s;
  rx_state_t       rx_state_r, rx_state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [7:0]      shift_r, shift_s;
  logic [2:0]      bitn_r, bitn_s;
  logic            byte_ld_s, frame_bad_s;
  logic [7:0]      byte_r;
  logic            byte_valid_r, frame_err_r;

  p_state_t        p_state_r, p_state_s, eff_state_s;
  logic [GW-1:0]   gap_r;
  logic            timeout_s;
  logic            ch_ld_s, hi_ld_s, fire_s;
  logic [1:0]      ch_r;
  logic [7:0]      hi_r, cmd_lo_s;
  logic            cmd_valid_r;
  logic [1:0]      cmd_ch_r;
  logic [W-1:0]    cmd_value_r;

  // two-flop synchronizer plus one more stage for 1->0 edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r    <= 1'b1;
      sync2_r    <= 1'b1;
      rxs_prev_r <= 1'b1;
    end else begin
      sync1_r    <= rx_i;
      sync2_r    <= sync1_r;
      rxs_prev_r <= sync2_r;
    end
  end

  assign rxs_s  = sync2_r;
  assign fall_s = rxs_prev_r & ~rxs_s;

  // receiver next-state: all sampling happens when the down-counter hits zero
  always_comb begin
    rx_state_s  = rx_state_r;
    cnt_s       = cnt_r;
    shift_s     = shift_r;
    bitn_s      = bitn_r;
    byte_ld_s   = 1'b0;
    frame_bad_s = 1'b0;
    case (rx_state_r)
      R_IDLE: begin
        if (fall_s) begin
          cnt_s      = HALF_LD;
          rx_state_s = R_START;
        end else begin
          rx_state_s = R_IDLE;
        end
      end
      R_START: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_s = cnt_r - CNT_ONE;
        end else if (rxs_s) begin
          rx_state_s = R_IDLE;
        end else begin
          cnt_s      = FULL_LD;
          bitn_s     = 3'd0;
          rx_state_s = R_DATA;
        end
      end
      R_DATA: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_s = cnt_r - CNT_ONE;
        end else begin
          shift_s = {rxs_s, shift_r[7:1]};
          cnt_s   = FULL_LD;
          if (bitn_r == 3'd7) begin
            rx_state_s = R_STOP;
          end else begin
            bitn_s = bitn_r + 3'd1;
          end
        end
      end
      R_STOP: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_s = cnt_r - CNT_ONE;
        end else begin
          if (rxs_s) begin
            byte_ld_s = 1'b1;
          end else begin
            frame_bad_s = 1'b1;
          end
          rx_state_s = R_IDLE;
        end
      end
      default: rx_state_s = R_IDLE;
    endcase
  end

  // receiver state and registered byte/strobe outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_r   <= R_IDLE;
      cnt_r        <= CNT_ZERO;
      shift_r      <= 8'd0;
      bitn_r       <= 3'd0;
      byte_r       <= 8'd0;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      rx_state_r   <= rx_state_s;
      cnt_r        <= cnt_s;
      shift_r      <= shift_s;
      bitn_r       <= bitn_s;
      byte_valid_r <= byte_ld_s;
      frame_err_r  <= frame_bad_s;
      if (byte_ld_s) begin
        byte_r <= shift_r;
      end
    end
  end

  // a timeout coinciding with a byte makes that byte the first one seen in P_SYNC
  assign timeout_s   = (p_state_r != P_SYNC) && (gap_r == GAP_MAX);
  assign eff_state_s = timeout_s ? P_SYNC : p_state_r;

`ifdef UART_CMD_CHECKSUM_EN
  logic       lo_ld_s, ck_bad_s, cksum_err_r;
  logic [7:0] lo_r;
  assign cmd_lo_s = lo_r;
`else
  assign cmd_lo_s = byte_r;
`endif

  // parser next-state, advanced only by received bytes, frame errors or the gap timer
  always_comb begin
    p_state_s = p_state_r;
    ch_ld_s   = 1'b0;
    hi_ld_s   = 1'b0;
    fire_s    = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    lo_ld_s   = 1'b0;
    ck_bad_s  = 1'b0;
`endif
    if (frame_err_r) begin
      p_state_s = P_SYNC;
    end else if (byte_valid_r) begin
      case (eff_state_s)
        P_SYNC: begin
          if (byte_r == SYNC_BYTE) begin
            p_state_s = P_CH;
          end else begin
            p_state_s = P_SYNC;
          end
        end
        P_CH: begin
          if (byte_r[7:2] == 6'd0) begin
            ch_ld_s   = 1'b1;
            p_state_s = P_HI;
          end else begin
            p_state_s = P_SYNC;
          end
        end
        P_HI: begin
          hi_ld_s   = 1'b1;
          p_state_s = P_LO;
        end
        P_LO: begin
`ifdef UART_CMD_CHECKSUM_EN
          lo_ld_s   = 1'b1;
          p_state_s = P_CK;
`else
          fire_s    = 1'b1;
          p_state_s = P_SYNC;
`endif
        end
`ifdef UART_CMD_CHECKSUM_EN
        P_CK: begin
          if (byte_r == cksum_f(ch_r, hi_r, lo_r)) begin
            fire_s = 1'b1;
          end else begin
            ck_bad_s = 1'b1;
          end
          p_state_s = P_SYNC;
        end
`endif
        default: p_state_s = P_SYNC;
      endcase
    end else if (timeout_s) begin
      p_state_s = P_SYNC;
    end else begin
      p_state_s = p_state_r;
    end
  end

  // parser state and inter-byte gap timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_state_r <= P_SYNC;
      gap_r     <= '0;
    end else begin
      p_state_r <= p_state_s;
      if (byte_valid_r || (p_state_r == P_SYNC) || timeout_s) begin
        gap_r <= '0;
      end else begin
        gap_r <= gap_r + GAP_ONE;
      end
    end
  end

  // packet field latches and registered command outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_r        <= 2'd0;
      hi_r        <= 8'd0;
      cmd_valid_r <= 1'b0;
      cmd_ch_r    <= 2'd0;
      cmd_value_r <= '0;
    end else begin
      cmd_valid_r <= fire_s;
      if (ch_ld_s) begin
        ch_r <= byte_r[1:0];
      end
      if (hi_ld_s) begin
        hi_r <= byte_r;
      end
      if (fire_s) begin
        cmd_ch_r    <= ch_r;
        cmd_value_r <= W'($signed({hi_r, cmd_lo_s}));
      end
    end
  end

`ifdef UART_CMD_CHECKSUM_EN
  // low byte latch and checksum-error strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_r        <= 8'd0;
      cksum_err_r <= 1'b0;
    end else begin
      cksum_err_r <= ck_bad_s;
      if (lo_ld_s) begin
        lo_r <= byte_r;
      end
    end
  end
  assign cksum_err_o = cksum_err_r;
`else
  assign cksum_err_o = 1'b0;
`endif

  assign byte_o       = byte_r;
  assign byte_valid_o = byte_valid_r;
  assign frame_err_o  = frame_err_r;
  assign cmd_valid_o  = cmd_valid_r;
  assign cmd_ch_o     = cmd_ch_r;
  assign cmd_value_o  = cmd_value_r;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: directed scenarios plus random packet stream, checked against
// expected bytes/commands derived from what was transmitted. Honours UART_CMD_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_uart_cmd_rx;
  localparam int DIV = 12;
  localparam int W = 16;
  localparam int TIMEOUT_BITS = 40;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_i = 1'b1;
  logic [7:0]   byte_o;
  logic         byte_valid_o, frame_err_o, cmd_valid_o, cksum_err_o;
  logic [1:0]   cmd_ch_o;
  logic [W-1:0] cmd_value_o;

  always #5 clk = ~clk;

  uart_cmd_rx #(.DIV(DIV), .W(W), .TIMEOUT_BITS(TIMEOUT_BITS)) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
    .frame_err_o(frame_err_o), .cmd_valid_o(cmd_valid_o), .cmd_ch_o(cmd_ch_o),
    .cmd_value_o(cmd_value_o), .cksum_err_o(cksum_err_o)
  );

  typedef struct {
    logic [1:0]   ch;
    logic [W-1:0] val;
    bit           bad;
  } cmd_t;

  cmd_t       exp_cmd_q[$];
  logic [7:0] exp_byte_q[$];
  int checks_n = 0, errors_n = 0;
  int bv_n = 0, fe_n = 0, cv_n = 0, ce_n = 0;
  int exp_bv = 0, exp_fe = 0, exp_cv = 0, exp_ce = 0;
  int cyc = 0, last_bv_cyc = 0, fall_cyc = 0;
  logic [1:0]   last_ch = 2'd0;
  logic [W-1:0] last_val = '0;
  logic         bv_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // observer: counts strobes, checks bytes and commands against the expectation queues
  always @(negedge clk) begin
    cmd_t c;
    if (rst) begin
      last_ch  = 2'd0;
      last_val = '0;
      bv_prev  = 1'b0;
    end else begin
      if (byte_valid_o) begin
        bv_n++;
        last_bv_cyc = cyc;
        check_eq("byte_q_nonempty", 64'(exp_byte_q.size() > 0), 64'd1);
        if (exp_byte_q.size() > 0) check_eq("byte", byte_o, exp_byte_q.pop_front());
      end
      if (frame_err_o) fe_n++;
      if (cmd_valid_o) cv_n++;
      if (cksum_err_o) ce_n++;
      if (cmd_valid_o || cksum_err_o) begin
        check_eq("strobe_lag", bv_prev, 1);
        check_eq("cmd_q_nonempty", 64'(exp_cmd_q.size() > 0), 64'd1);
        if (exp_cmd_q.size() > 0) begin
          c = exp_cmd_q.pop_front();
          check_eq("cmd_kind", cksum_err_o, c.bad);
          if (!c.bad) begin
            last_ch  = c.ch;
            last_val = c.val;
          end
          check_eq("cmd_ch", cmd_ch_o, last_ch);
          check_eq("cmd_val", cmd_value_o, last_val);
        end
      end
      bv_prev = byte_valid_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      exp_byte_q.push_back(b);
      exp_bv++;
    end else begin
      exp_fe++;
    end
    rx_i = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      tick(DIV);
    end
    rx_i = stop;
    tick(DIV);
    rx_i = 1'b1;
  endtask

  function automatic logic [W-1:0] sext16(input logic [7:0] hi, input logic [7:0] lo);
    int v;
    v = int'(hi) * 256 + int'(lo);
    if (v >= 32768) v = v - 65536;
    return W'(v);
  endfunction

  // full packet; ck_flip != 0 corrupts the checksum byte (only meaningful with checksum)
  task automatic send_cmd(input logic [1:0] ch, input logic [7:0] hi, input logic [7:0] lo,
                          input logic [7:0] ck_flip, input int gap);
    cmd_t c;
    logic [7:0] ck;
    c.ch  = ch;
    c.val = sext16(hi, lo);
    ck    = {6'd0, ch} ^ hi ^ lo ^ ck_flip;
    send_frame(8'hA5, 1'b1); tick(gap);
    send_frame({6'd0, ch}, 1'b1); tick(gap);
    send_frame(hi, 1'b1); tick(gap);
`ifdef UART_CMD_CHECKSUM_EN
    c.bad = (ck_flip != 8'd0);
    send_frame(lo, 1'b1); tick(gap);
    exp_cmd_q.push_back(c);
    if (c.bad) exp_ce++; else exp_cv++;
    send_frame(ck, 1'b1);
`else
    c.bad = 1'b0;
    exp_cmd_q.push_back(c);
    exp_cv++;
    send_frame(lo, 1'b1);
`endif
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_bv"}, bv_n, exp_bv);
    check_eq({tag, "_fe"}, fe_n, exp_fe);
    check_eq({tag, "_cv"}, cv_n, exp_cv);
    check_eq({tag, "_ce"}, ce_n, exp_ce);
  endtask

  initial begin
    logic [7:0] b;
    int lat, junk, kind;
    rst = 1'b1;
    tick(3);
    check_eq("rst_outs", {byte_o, byte_valid_o, frame_err_o, cmd_valid_o, cmd_ch_o, cmd_value_o, cksum_err_o}, 0);
    tick(2);
    rst = 1'b0;
    tick(2000);
    check_eq("idle_outs", {byte_o, byte_valid_o, frame_err_o, cmd_valid_o, cmd_ch_o, cmd_value_o, cksum_err_o}, 0);
    check_counts("idle");

    // single byte latency from rx_i falling edge
    fall_cyc = cyc;
    send_frame(8'h3C, 1'b1);
    tick(DIV);
    lat = last_bv_cyc - fall_cyc;
    check_eq("latency_window", 64'((lat >= 116) && (lat <= 120)), 64'd1);
    check_counts("byte3c");

    // glitch shorter than half a bit, then a framing error
    rx_i = 1'b0;
    tick(3);
    rx_i = 1'b1;
    tick(3 * DIV);
    check_counts("glitch");
    send_frame(8'h55, 1'b0);
    tick(3 * DIV);
    check_counts("frame_err");

    send_cmd(2'd2, 8'hB1, 8'hE0, 8'h00, 0);
    tick(2 * DIV);
    check_eq("cmd_neg_val", cmd_value_o, 16'hB1E0);
    check_eq("cmd_neg_ch", cmd_ch_o, 2'd2);
    check_counts("cmd_neg");
`ifdef UART_CMD_CHECKSUM_EN
    send_cmd(2'd1, 8'hB1, 8'hE0, 8'h07, 0);
    tick(2 * DIV);
    check_eq("ckerr_hold_val", cmd_value_o, 16'hB1E0);
    check_counts("ckerr");
`endif

    // inter-byte gap beyond the timeout drops the partial packet
    send_frame(8'hA5, 1'b1);
    send_frame(8'h01, 1'b1);
    tick(41 * DIV);
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    tick(2 * DIV);
    check_counts("timeout");
    send_cmd(2'd0, 8'h4E, 8'h20, 8'h00, 0);
    tick(2 * DIV);
    check_eq("cmd_pos_val", cmd_value_o, 16'h4E20);
    check_eq("cmd_pos_ch", cmd_ch_o, 2'd0);
    check_counts("cmd_pos");

    // reset during bit 4 of the third byte
    send_frame(8'hA5, 1'b1);
    send_frame(8'h02, 1'b1);
    b = 8'h5A;
    rx_i = 1'b0;
    tick(DIV);
    for (int i = 0; i < 4; i++) begin
      rx_i = b[i];
      tick(DIV);
    end
    rx_i = b[4];
    tick(DIV / 2);
    rst = 1'b1;
    #1;
    check_eq("midrst_outs", {byte_o, byte_valid_o, frame_err_o, cmd_valid_o, cmd_ch_o, cmd_value_o, cksum_err_o}, 0);
    rx_i = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(3 * DIV);
    check_counts("midrst");
    send_cmd(2'd3, 8'h7F, 8'hFF, 8'h00, 0);
    tick(2 * DIV);
    check_eq("post_rst_val", cmd_value_o, 16'h7FFF);
    check_counts("post_rst");

    // random stream: junk bytes, good packets, bad-channel packets, bad checksums
    for (int p = 0; p < 25; p++) begin
      junk = $urandom_range(0, 2);
      for (int j = 0; j < junk; j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        send_frame(b, 1'b1);
        tick($urandom_range(0, 2 * DIV));
      end
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        send_frame(8'hA5, 1'b1);
        b = 8'($urandom_range(4, 255));
        if (b == 8'hA5) b = 8'hC3;
        send_frame(b, 1'b1);
      end else begin
        send_cmd(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 (kind == 3) ? 8'($urandom_range(1, 255)) : 8'h00, $urandom_range(0, 2 * DIV));
      end
      tick($urandom_range(1, 3 * DIV));
    end
    tick(3 * DIV);
    check_counts("final");
    check_eq("final_byte_q", exp_byte_q.size(), 0);
    check_eq("final_cmd_q", exp_cmd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end
endmodule
